dice_roller: RTL

Generates the five die values (1–6) that the 7-segment display stage shows on digits 0–4, and enforces the per-turn roll rules. Each accepted roll request runs a timed "tumbling" animation: unheld dice change value on every animation tick, then settle, and a one-cycle `roll_done` is emitted to the game FSM. Held dice keep their values. Randomness comes from a free-running 16-bit LFSR.

---
 rtl/dice_roller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dice_roller.sv
// dice_roller: five-die value generator with a timed tumbling animation.
// Unheld dice reload from a free-running 16-bit Galois LFSR on every animation
// tick while rolling. The block allows at most three rolls per turn.
// All outputs are registered; there is no combinational input-to-output path.

module dice_roller #(
  parameter int TICK_DIV    = 2_500_000,
  parameter int ROLL_CYCLES = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [4:0] hold,
  input  logic       new_turn,
  output logic [2:0] d1,
  output logic [2:0] d2,
  output logic [2:0] d3,
  output logic [2:0] d4,
  output logic [2:0] d5,
  output logic       rolling,
  output logic       roll_done,
  output logic [1:0] roll_count
);

  // Counter widths. Each counter is at least one bit wide, even when a
  // parameter is 1.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ZERO = TW'(0);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [AW-1:0] ANIM_LOAD = AW'(ROLL_CYCLES);
  localparam logic [AW-1:0] ANIM_ONE  = AW'(1);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [1:0]  COUNT_MAX = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ROLL = 1'b1
  } state_t;

  // Galois step: shift right, fold the tap mask back in when a one falls out.
  // A non-zero state never maps to zero, so the register stays out of the lock-up state.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = {1'b0, cur[15:1]};
    if (cur[0]) begin
      lfsr_step = shifted ^ LFSR_MASK;
    end else begin
      lfsr_step = shifted;
    end
  endfunction

  // Map a 3-bit random slice onto a die face. The values 6 and 7 fold onto 1 and 2.
  function automatic logic [2:0] map_die(input logic [2:0] r);
    case (r)
      3'd6:    map_die = 3'd1;
      3'd7:    map_die = 3'd2;
      default: map_die = r + 3'd1;
    endcase
  endfunction

  state_t          state_r,  state_s;
  logic [15:0]     lfsr_r,   lfsr_s;
  logic [TW-1:0]   tick_r,   tick_s;
  logic [AW-1:0]   anim_r,   anim_s;
  logic [4:0]      hold_r,   hold_s;
  logic [1:0]      count_r,  count_s;
  logic            done_r,   done_s;
  logic            rolling_r, rolling_s;
  logic [4:0][2:0] die_r,    die_s;

  // Next-state logic for the roll FSM, the counters, the dice and the LFSR.
  always_comb begin
    state_s = state_r;
    lfsr_s  = lfsr_step(lfsr_r);
    tick_s  = tick_r;
    anim_s  = anim_r;
    hold_s  = hold_r;
    count_s = count_r;
    done_s  = 1'b0;
    die_s   = die_r;

    case (state_r)
      IDLE: begin
        if (new_turn) begin
          // new_turn has priority over a same-cycle roll request.
          count_s = 2'd0;
        end else if (roll_req && (count_r != COUNT_MAX)) begin
          // The first roll of a turn rolls every die, whatever the hold mask says.
          if (count_r != 2'd0) begin
            hold_s = hold;
          end else begin
            hold_s = 5'b00000;
          end
          anim_s  = ANIM_LOAD;
          tick_s  = TICK_ZERO;
          state_s = ROLL;
        end else begin
          state_s = IDLE;
        end
      end

      ROLL: begin
        if (tick_r == TICK_LAST) begin
          tick_s = TICK_ZERO;
          for (int k = 0; k < 5; k++) begin
            if (hold_r[k]) begin
              die_s[k] = die_r[k];
            end else begin
              die_s[k] = map_die(lfsr_r[3*k +: 3]);
            end
          end
          if (anim_r == ANIM_ONE) begin
            // This is the last tick: the dice settle and the roll is counted.
            state_s = IDLE;
            done_s  = 1'b1;
            if (count_r == COUNT_MAX) begin
              count_s = COUNT_MAX;
            end else begin
              count_s = count_r + 2'd1;
            end
          end else begin
            anim_s = anim_r - ANIM_ONE;
          end
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    rolling_s = (state_s == ROLL);
  end

  // State register. Reset aborts any roll in progress and restores the power-up dice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      lfsr_r    <= LFSR_SEED;
      tick_r    <= TICK_ZERO;
      anim_r    <= {AW{1'b0}};
      hold_r    <= 5'b00000;
      count_r   <= 2'd0;
      done_r    <= 1'b0;
      rolling_r <= 1'b0;
      die_r     <= {5{3'd1}};
    end else begin
      state_r   <= state_s;
      lfsr_r    <= lfsr_s;
      tick_r    <= tick_s;
      anim_r    <= anim_s;
      hold_r    <= hold_s;
      count_r   <= count_s;
      done_r    <= done_s;
      rolling_r <= rolling_s;
      die_r     <= die_s;
    end
  end

  assign d1         = die_r[0];
  assign d2         = die_r[1];
  assign d3         = die_r[2];
  assign d4         = die_r[3];
  assign d5         = die_r[4];
  assign rolling    = rolling_r;
  assign roll_done  = done_r;
  assign roll_count = count_r;

endmodule
